// File: rtl/sys_pkg.sv
// Shared sizing helpers and the saturating accumulate used by every systolic column.
// Arithmetic is carried at ACC_MAXW bits so one function serves any ACC_WIDTH up to ACC_MAXW-1.
package sys_pkg;

   localparam int ACC_MAXW = 128;

   typedef logic signed [ACC_MAXW-1:0] wide_t;

   typedef struct packed {
      logic  ovf;
      wide_t val;
   } sat_res_t;

   function automatic int acc_width(input int dw);
      return 2 * dw;
   endfunction

   function automatic wide_t acc_max(input int aw);
      return (wide_t'(1) <<< (aw - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t acc_min(input int aw);
      return -(wide_t'(1) <<< (aw - 1));
   endfunction

   // Caller keeps the low aw bits; with sat_en=0 that truncation is the wrap.
   function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int aw,
                                        input bit sat_en);
      sat_res_t r;
      wide_t    s;
      s     = a + b;
      r.ovf = (s > acc_max(aw)) || (s < acc_min(aw));
      r.val = s;
      if (sat_en && r.ovf)
         r.val = s[ACC_MAXW-1] ? acc_min(aw) : acc_max(aw);
      return r;
   endfunction

endpackage

// File: rtl/pe_db.sv
// One weight-stationary column: active/shadow weights, MAC with optional saturation,
// and the en/act/swap wavefront registers feeding the next column.
module pe_db
   import sys_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH),
   parameter int SAT_EN     = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en_i,
   input  logic                         swap_i,
   input  logic                         ld_i,
   input  logic signed [DATA_WIDTH-1:0] act_i,
   input  logic signed [DATA_WIDTH-1:0] shd_i,
   input  logic signed [ACC_WIDTH-1:0]  psum_i,
   output logic                         en_o,
   output logic                         swap_o,
   output logic                         ovf_o,
   output logic signed [DATA_WIDTH-1:0] act_o,
   output logic signed [DATA_WIDTH-1:0] shd_o,
   output logic signed [ACC_WIDTH-1:0]  psum_o
);

   localparam int PW = 2 * DATA_WIDTH;

   logic signed [DATA_WIDTH-1:0] act_q, shd_q, shd_d, w_q, w_d, w_eff;
   logic signed [ACC_WIDTH-1:0]  psum_q, psum_d;
   logic                         en_q, swap_q, ovf_q, ovf_d;
   logic signed [PW-1:0]         prod;
   wide_t                        prod_x, psum_x;
   sat_res_t                     sum;
   logic                         unused_hi;

   // The swap token and the activation travel together, so the MAC must see the
   // incoming weight in the same cycle the copy happens.
   assign w_eff  = swap_i ? shd_q : w_q;
   assign prod   = PW'(act_i) * PW'(w_eff);
   assign prod_x = {{(ACC_MAXW-PW){prod[PW-1]}}, prod};
   assign psum_x = {{(ACC_MAXW-ACC_WIDTH){psum_i[ACC_WIDTH-1]}}, psum_i};
   assign sum    = sat_add(psum_x, prod_x, ACC_WIDTH, SAT_EN != 0);
   assign unused_hi = ^sum.val[ACC_MAXW-1:ACC_WIDTH];

   always_comb begin
      psum_d = psum_q;
      ovf_d  = 1'b0;
      w_d    = w_q;
      shd_d  = shd_q;
      if (en_i) begin
         psum_d = sum.val[ACC_WIDTH-1:0];
         ovf_d  = sum.ovf;
      end
      if (swap_i)
         w_d = shd_q;
      if (ld_i)
         shd_d = shd_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_q  <= '0;
         en_q   <= 1'b0;
         swap_q <= 1'b0;
         shd_q  <= '0;
         w_q    <= '0;
         psum_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         act_q  <= act_i;
         en_q   <= en_i;
         swap_q <= swap_i;
         shd_q  <= shd_d;
         w_q    <= w_d;
         psum_q <= psum_d;
         ovf_q  <= ovf_d;
      end
   end

   assign en_o   = en_q;
   assign swap_o = swap_q;
   assign ovf_o  = ovf_q;
   assign act_o  = act_q;
   assign shd_o  = shd_q;
   assign psum_o = psum_q;

endmodule

// File: rtl/sys_row_db.sv
// Systolic MAC row with a double-buffered weight chain; the swap token rides the
// activation wavefront so weights change without draining the row.
module sys_row_db
   import sys_pkg::*;
#(
   parameter int SYS_COL    = 16,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH),
   parameter int SAT_EN     = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en_in,
   input  logic signed [DATA_WIDTH-1:0]    act_in,
   input  logic                            swap_in,
   input  logic                            w_ld_valid,
   input  logic signed [DATA_WIDTH-1:0]    w_ld_data,
   output logic                            w_ld_ready,
   input  logic [SYS_COL*ACC_WIDTH-1:0]    psum_in,
   output logic [SYS_COL-1:0]              en_out,
   output logic [SYS_COL*ACC_WIDTH-1:0]    psum_out,
   output logic [SYS_COL-1:0]              ovf_out,
   output logic signed [DATA_WIDTH-1:0]    act_out
);

   localparam int CW = $clog2(SYS_COL + 1);
   localparam logic [CW-1:0] FULL = CW'(SYS_COL);

   logic [CW-1:0] cnt_q, cnt_d, busy_q, busy_d;
   logic          busy, ld_acc, swap_acc;
   logic                            unused_shd;
   logic [SYS_COL:0]                en_c, swap_c;
   logic [SYS_COL:0][DATA_WIDTH-1:0] act_c, shd_c;

   assign busy       = busy_q != '0;
   assign w_ld_ready = !rst && !busy && (cnt_q < FULL);
   assign ld_acc     = w_ld_valid && w_ld_ready;
   assign swap_acc   = swap_in && !busy && (cnt_q == FULL);

   // busy spans the cycles the token is still walking toward the last column.
   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (swap_acc) begin
         cnt_d  = '0;
         busy_d = FULL;
      end else begin
         if (ld_acc)
            cnt_d = cnt_q + 1'b1;
         if (busy)
            busy_d = busy_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         busy_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign en_c[0]   = en_in;
   assign swap_c[0] = swap_acc;
   assign act_c[0]  = act_in;
   assign shd_c[0]  = w_ld_data;

   for (genvar i = 0; i < SYS_COL; i++) begin : g_col
      pe_db #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH),
         .SAT_EN     (SAT_EN)
      ) u_pe (
         .clk    (clk),
         .rst    (rst),
         .en_i   (en_c[i]),
         .swap_i (swap_c[i]),
         .ld_i   (ld_acc),
         .act_i  (act_c[i]),
         .shd_i  (shd_c[i]),
         .psum_i (psum_in[i*ACC_WIDTH +: ACC_WIDTH]),
         .en_o   (en_c[i+1]),
         .swap_o (swap_c[i+1]),
         .ovf_o  (ovf_out[i]),
         .act_o  (act_c[i+1]),
         .shd_o  (shd_c[i+1]),
         .psum_o (psum_out[i*ACC_WIDTH +: ACC_WIDTH])
      );
   end

   assign en_out     = en_c[SYS_COL:1];
   assign act_out    = act_c[SYS_COL];
   assign unused_shd = ^{shd_c[SYS_COL], swap_c[SYS_COL]};

endmodule

// File: tb/tb_sys_row_db.sv
// Bench for sys_row_db: directed wavefront/swap/saturation scenarios plus a random
// run checked against a cycle-indexed history model of the row.
module tb_sys_row_db;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 16;
   localparam int HMAX = 4096;

   logic clk = 1'b0;
   logic rst, en_in, swap_in, w_ld_valid;
   logic signed [DW-1:0] act_in, w_ld_data;
   logic [N*AW-1:0] psum_in;
   logic rdy_s, rdy_w;
   logic [N-1:0] en_s, en_w, ovf_s, ovf_w;
   logic [N*AW-1:0] ps_s, ps_w;
   logic signed [DW-1:0] act_s, act_w;

   always #5 clk = ~clk;

   sys_row_db #(.SYS_COL(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SAT_EN(1)) dut_s (
      .clk(clk), .rst(rst), .en_in(en_in), .act_in(act_in), .swap_in(swap_in),
      .w_ld_valid(w_ld_valid), .w_ld_data(w_ld_data), .w_ld_ready(rdy_s),
      .psum_in(psum_in), .en_out(en_s), .psum_out(ps_s), .ovf_out(ovf_s), .act_out(act_s));

   sys_row_db #(.SYS_COL(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SAT_EN(0)) dut_w (
      .clk(clk), .rst(rst), .en_in(en_in), .act_in(act_in), .swap_in(swap_in),
      .w_ld_valid(w_ld_valid), .w_ld_data(w_ld_data), .w_ld_ready(rdy_w),
      .psum_in(psum_in), .en_out(en_w), .psum_out(ps_w), .ovf_out(ovf_w), .act_out(act_w));

   int n_run = 0, n_fail = 0;

   // Reference: per-cycle history of what entered column 0 and which weight set it saw.
   bit h_en[HMAX];
   int h_act[HMAX];
   int h_w[HMAX][N];
   int m_sh[N], m_w[N];
   int m_cnt = 0, m_busy = 0, cyc_n = 0, h_base = 0;
   int e_ps_s[N], e_ps_w[N];
   bit e_en[N], e_ovf[N];
   int e_act = 0;

   function automatic int col(input logic [N*AW-1:0] v, input int i);
      return $signed(v[i*AW +: AW]);
   endfunction

   function automatic bit m_ready();
      return !rst && m_busy == 0 && m_cnt < N;
   endfunction

   function automatic void calc(input int ps, input int a, input int w, input bit sat,
                                output int r, output bit o);
      int s;
      s = ps + a * w;
      o = (s > 32767) || (s < -32768);
      if (!o)     r = s;
      else if (sat) r = (s > 0) ? 32767 : -32768;
      else        r = ((s + 32768) & 65535) - 32768;
   endfunction

   task automatic model_edge();
      bit ld, sw, o;
      int idx, r;
      if (rst) begin
         foreach (m_sh[i]) begin
            m_sh[i] = 0; m_w[i] = 0; e_ps_s[i] = 0; e_ps_w[i] = 0; e_en[i] = 0; e_ovf[i] = 0;
         end
         m_cnt = 0; m_busy = 0; e_act = 0; h_base = cyc_n + 1;
      end else begin
         ld = w_ld_valid && m_ready();
         sw = swap_in && m_busy == 0 && m_cnt == N;
         if (sw) m_w = m_sh;
         h_en[cyc_n] = en_in;
         h_act[cyc_n] = act_in;
         foreach (m_w[i]) h_w[cyc_n][i] = m_w[i];
         for (int i = 0; i < N; i++) begin
            idx = cyc_n - i;
            e_en[i] = 0; e_ovf[i] = 0;
            if (idx >= h_base && h_en[idx]) begin
               calc(col(psum_in, i), h_act[idx], h_w[idx][i], 1'b1, r, o);
               e_ps_s[i] = r; e_ovf[i] = o;
               calc(col(psum_in, i), h_act[idx], h_w[idx][i], 1'b0, r, o);
               e_ps_w[i] = r; e_en[i] = 1;
            end
         end
         idx = cyc_n - (N - 1);
         e_act = (idx >= h_base) ? h_act[idx] : 0;
         if (ld) begin
            for (int i = N - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
            m_sh[0] = w_ld_data;
            m_cnt++;
         end
         if (sw) begin m_cnt = 0; m_busy = N; end
         else if (m_busy > 0) m_busy--;
      end
      cyc_n++;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      en_in = 0; act_in = '0; swap_in = 0; w_ld_valid = 0; w_ld_data = '0; psum_in = '0;
   endtask

   task automatic load4(input int v);
      w_ld_valid = 1; w_ld_data = DW'(v);
      repeat (N) cyc();
      w_ld_valid = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle();
      cyc(); cyc();
      n_run++; if (rdy_s !== 1'b0) begin n_fail++; $display("FAIL rst_rdy got %0b exp 0", rdy_s); end
      n_run++; if (ps_s !== '0 || ps_w !== '0) begin n_fail++; $display("FAIL rst_psum got %h/%h exp 0", ps_s, ps_w); end
      n_run++; if (en_s !== '0 || ovf_s !== '0) begin n_fail++; $display("FAIL rst_en_ovf got %b/%b exp 0", en_s, ovf_s); end
      n_run++; if (act_s !== '0) begin n_fail++; $display("FAIL rst_act got %0d exp 0", act_s); end
      rst = 0; #1;
      n_run++; if (rdy_s !== 1'b1) begin n_fail++; $display("FAIL rst_rdy_rel got %0b exp 1", rdy_s); end
   endtask

   task automatic test_basic();
      int exp[N] = '{20, 15, 10, 5};
      w_ld_valid = 1;
      for (int v = 1; v <= N; v++) begin w_ld_data = DW'(v); cyc(); end
      #1;
      n_run++; if (rdy_s !== 1'b0) begin n_fail++; $display("FAIL ld_full_rdy got %0b exp 0", rdy_s); end
      w_ld_data = 9; cyc();
      w_ld_valid = 0;
      swap_in = 1; en_in = 1; act_in = 5; psum_in = '0;
      cyc();
      swap_in = 0; en_in = 0; act_in = 0;
      for (int k = 0; k < N; k++) begin
         n_run++; if (col(ps_s, k) !== exp[k]) begin n_fail++; $display("FAIL basic_psum col%0d got %0d exp %0d", k, col(ps_s, k), exp[k]); end
         n_run++; if (en_s !== N'(1 << k)) begin n_fail++; $display("FAIL basic_en t+%0d got %b exp %b", k+1, en_s, N'(1 << k)); end
         n_run++; if (rdy_s !== 1'b0) begin n_fail++; $display("FAIL busy_rdy t+%0d got %0b exp 0", k+1, rdy_s); end
         cyc();
      end
      n_run++; if (rdy_s !== 1'b1) begin n_fail++; $display("FAIL rdy_back got %0b exp 1", rdy_s); end
   endtask

   task automatic test_sat();
      load4(127);
      swap_in = 1; en_in = 1; act_in = 127; psum_in = {N{16'sd20000}};
      cyc();
      swap_in = 0; en_in = 0;
      for (int k = 0; k < N; k++) begin
         n_run++; if (col(ps_s, k) !== 32767 || ovf_s !== N'(1 << k)) begin n_fail++; $display("FAIL sat col%0d got %0d ovf %b exp 32767 ovf %b", k, col(ps_s, k), ovf_s, N'(1 << k)); end
         n_run++; if (col(ps_w, k) !== -29407 || ovf_w !== N'(1 << k)) begin n_fail++; $display("FAIL wrap col%0d got %0d ovf %b exp -29407 ovf %b", k, col(ps_w, k), ovf_w, N'(1 << k)); end
         cyc();
      end
      psum_in = '0;
   endtask

   task automatic test_swap_stream();
      int obs[12][N];
      load4(1);
      swap_in = 1; cyc(); swap_in = 0;
      repeat (N) cyc();
      load4(2);
      psum_in = {N{16'sd100}}; en_in = 1; act_in = 1;
      for (int s = 0; s < 10; s++) begin
         swap_in = (s == 3);
         cyc();
         for (int i = 0; i < N; i++) obs[s+1][i] = col(ps_s, i);
      end
      idle();
      for (int i = 0; i < N; i++) begin
         n_run++; if (obs[3+i][i] !== 101) begin n_fail++; $display("FAIL old_w col%0d got %0d exp 101", i, obs[3+i][i]); end
         n_run++; if (obs[4+i][i] !== 102) begin n_fail++; $display("FAIL new_w col%0d got %0d exp 102", i, obs[4+i][i]); end
      end
   endtask

   task automatic test_handshake();
      w_ld_valid = 1; w_ld_data = 7;
      repeat (3) cyc();
      w_ld_valid = 0; swap_in = 1;
      cyc();
      swap_in = 0; #1;
      n_run++; if (rdy_s !== 1'b1) begin n_fail++; $display("FAIL swap_ign_rdy got %0b exp 1", rdy_s); end
      en_in = 1; act_in = 1; psum_in = '0;
      cyc();
      en_in = 0;
      n_run++; if (col(ps_s, 0) !== 2) begin n_fail++; $display("FAIL swap_ign_w got %0d exp 2", col(ps_s, 0)); end
      w_ld_valid = 1; cyc(); w_ld_valid = 0; #1;
      n_run++; if (rdy_s !== 1'b0) begin n_fail++; $display("FAIL cnt_kept_rdy got %0b exp 0", rdy_s); end
   endtask

   task automatic test_reset_mid_swap();
      swap_in = 1; cyc(); swap_in = 0;
      rst = 1; cyc(); rst = 0; #1;
      n_run++; if (rdy_s !== 1'b1) begin n_fail++; $display("FAIL rms_rdy got %0b exp 1", rdy_s); end
      n_run++; if (en_s !== '0 || ps_s !== '0 || ps_w !== '0) begin n_fail++; $display("FAIL rms_clr got en %b ps %h exp 0", en_s, ps_s); end
      en_in = 1; act_in = DW'($urandom_range(1, 100)); psum_in = {N{16'sd7}};
      cyc();
      en_in = 0;
      for (int k = 0; k < N; k++) begin
         n_run++; if (col(ps_s, k) !== 7 || en_s !== N'(1 << k)) begin n_fail++; $display("FAIL rms_mac col%0d got %0d en %b exp 7", k, col(ps_s, k), en_s); end
         cyc();
      end
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         rst        = ($urandom_range(0, 99) < 2);
         en_in      = $urandom_range(0, 1);
         act_in     = DW'($urandom);
         swap_in    = ($urandom_range(0, 99) < 15);
         w_ld_valid = ($urandom_range(0, 99) < 60);
         w_ld_data  = DW'($urandom);
         for (int i = 0; i < N; i++) psum_in[i*AW +: AW] = AW'($urandom);
         #1;
         n_run++; if (rdy_s !== m_ready() || rdy_w !== m_ready()) begin n_fail++; $display("FAIL rnd_rdy c%0d got %0b exp %0b", c, rdy_s, m_ready()); end
         n_run++; if (int'(act_s) !== e_act) begin n_fail++; $display("FAIL rnd_act c%0d got %0d exp %0d", c, act_s, e_act); end
         for (int i = 0; i < N; i++) begin
            n_run++;
            if (col(ps_s, i) !== e_ps_s[i] || col(ps_w, i) !== e_ps_w[i] || en_s[i] !== e_en[i] ||
                en_w[i] !== e_en[i] || ovf_s[i] !== e_ovf[i] || ovf_w[i] !== e_ovf[i]) begin
               n_fail++;
               $display("FAIL rnd_col c%0d col%0d got s=%0d w=%0d en=%b ovf=%b exp s=%0d w=%0d en=%b ovf=%b",
                        c, i, col(ps_s, i), col(ps_w, i), en_s[i], ovf_s[i], e_ps_s[i], e_ps_w[i], e_en[i], e_ovf[i]);
            end
         end
         cyc();
      end
      idle(); rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1; idle();
      test_reset();
      test_basic();
      test_sat();
      test_swap_stream();
      test_handshake();
      test_reset_mid_swap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/sys_row_db.md
Name: sys_row_db

Overview:
Next-generation systolic MAC row: SYS_COL weight-stationary PEs with a skewed activation/enable wavefront and a configurable accumulator width. Adds serial double-buffered weight loading (shadow chain) and a swap token that rides the wavefront, so weights are replaced without draining the row. Optional saturating accumulation. Rows stack vertically through psum_in/psum_out inside the MMU array.

Parameters:
SYS_COL, 16, number of PE columns (>=2)
DATA_WIDTH, 16, signed activation/weight width
ACC_WIDTH, 2*DATA_WIDTH, signed partial-sum width per column (>=2*DATA_WIDTH)
SAT_EN, 1, 1 = saturate accumulation to ACC_WIDTH range; 0 = two's-complement wrap

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
en_in  in  1  activation valid entering column 0
act_in  in  DATA_WIDTH  signed activation entering column 0
swap_in  in  1  request to commit shadow weights to active weights
w_ld_valid  in  1  weight load strobe
w_ld_data  in  DATA_WIDTH  weight word shifted into the shadow chain
w_ld_ready  out  1  shadow chain accepts a load this cycle
psum_in  in  SYS_COL*ACC_WIDTH  partial sums from the row above, column i at slice i
en_out  out  SYS_COL  per-column registered valid, aligned with psum_out
psum_out  out  SYS_COL*ACC_WIDTH  registered partial sums, column i at slice i
ovf_out  out  SYS_COL  per-column pulse: saturation or wrap occurred on this update
act_out  out  DATA_WIDTH  activation leaving the last column, for chaining

Behaviour:
- Reset: active/shadow weights 0, psum_out 0, en_out 0, ovf_out 0, act_out 0, load count 0, busy 0, swap pipeline cleared. w_ld_ready is 0 while rst is high.
- Wavefront: en_in/act_in/swap token at cycle t reach column i at cycle t+i. Column i registers on the edge ending cycle t+i, so en_out[i] is high in cycle t+i+1.
- MAC: when enabled at column i: psum_out[i] <= psum_in[i] + act*w_active[i]. The product is full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH+1 before the add.
  - SAT_EN=1: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - SAT_EN=0: truncate.
  - ovf_out[i]=1 when clamp or wrap occurred, else 0.
  - When not enabled, psum_out[i] holds and ovf_out[i]=0.
- Load:
  - w_ld_ready = !busy && cnt<SYS_COL.
  - A load (valid&&ready) shifts the shadow chain from column 0 toward SYS_COL-1 and increments cnt.
  - After SYS_COL loads, load k resides in column SYS_COL-1-k.
  - A load strobe while ready is 0 is ignored.
- Swap:
  - Accepted only if cnt==SYS_COL && !busy; otherwise ignored with no side effects.
  - Accepted at cycle t: column i copies shadow to active on the edge ending cycle t+i.
  - An activation entering at t uses new weights in every column; one entering at t-1 uses old weights in every column.
  - cnt <= 0 at the t edge; busy high for cycles t+1..t+SYS_COL, then w_ld_ready returns to 1.
- Simultaneous events: load and swap in the same cycle cannot both be accepted, since swap requires cnt==SYS_COL, which forces ready to 0. Swap with en_in in the same cycle is the normal case.
- Reset mid-swap aborts the swap; all weights return to 0.

Decomposition:
- Package sys_pkg: ACC width helper, saturation bound constants (max/min for ACC_WIDTH), and the saturating-add function shared with the column adders.
- Sub-module pe_db: one column, containing the active and shadow registers, the MAC with saturation, and the en/act/swap pipeline registers.
- sys_row_db: instantiates pe_db via generate and owns cnt, busy and w_ld_ready.

Test Plan:
- Bench config SYS_COL=4, DATA_WIDTH=8, ACC_WIDTH=16. Load 1,2,3,4, then swap, then en_in with act=5 and psum_in=0 at t -> psum_out = 20, 15, 10, 5 at columns 0..3, in cycles t+1..t+4 respectively.
- Weights 127, act 127, psum_in 20000, SAT_EN=1 -> psum_out 32767 with ovf=1. Same stimulus with SAT_EN=0 -> -29407 with ovf=1.
- Old weights all 1, new weights all 2, act=1 streamed every cycle, swap at t3:
  - activation entering at t2 -> every column adds 1;
  - activation entering at t3 -> every column adds 2.
- Handshake:
  - w_ld_ready drops after the 4th load; a 5th strobe leaves the shadow unchanged.
  - Swap at cnt=3 is ignored.
  - After an accepted swap, ready is low for exactly 4 cycles.
- Assert rst at t+1 of a swap -> all weights 0, en_out=0, psum_out=0, w_ld_ready=1 one cycle after rst deasserts, and subsequent MACs with psum_in=7 return 7.
